// File: rtl/map_door_renderer.sv
// Cross-wall map renderer with four animated sliding doors (L, R, T, B).
// Pixel colour is registered: oled_data follows x/y by exactly one cycle.
module map_door_renderer #(
   parameter int          H_Y0     = 27,
   parameter int          V_X0     = 43,
   parameter int          WALL_T   = 8,
   parameter int          GAP_W    = 12,
   parameter int          GL_X0    = 10,
   parameter int          GR_X0    = 70,
   parameter int          GT_Y0    = 6,
   parameter int          GB_Y0    = 48,
   parameter logic [15:0] WALL_COL = 16'hFFE0,
   parameter logic [15:0] DOOR_COL = 16'hF800,
   parameter logic [15:0] BG_COL   = 16'h0000
) (
   input  logic        basys_clk,
   input  logic        reset,
   input  logic [6:0]  x,
   input  logic [6:0]  y,
   input  logic        frame_tick,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_id,
   input  logic        cmd_open,
   output logic [15:0] oled_data,
   output logic [3:0]  door_open,
   output logic [3:0]  door_moving
);

   localparam int         W_PIX  = 96;
   localparam int         H_PIX  = 64;
   localparam logic [4:0] AMT_MX = 5'(GAP_W);
   localparam logic [4:0] AMT_M1 = 5'(GAP_W - 1);

   typedef enum logic [1:0] {
      CLOSED,
      OPENING,
      OPEN,
      CLOSING
   } door_st_e;

   door_st_e    st_q  [4];
   door_st_e    st_d  [4];
   logic [4:0]  amt_q [4];
   logic [4:0]  amt_d [4];
   logic [3:0]  take_c;
   logic [15:0] pix_q;
   logic [15:0] pix_d;

   int   xi;
   int   yi;
   logic in_rng;
   logic in_h;
   logic in_v;
   logic in_dl;
   logic in_dr;
   logic in_dt;
   logic in_db;

   always_ff @(posedge basys_clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            st_q[i]  <= CLOSED;
            amt_q[i] <= '0;
         end
         pix_q <= BG_COL;
      end else begin
         for (int i = 0; i < 4; i++) begin
            st_q[i]  <= st_d[i];
            amt_q[i] <= amt_d[i];
         end
         pix_q <= pix_d;
      end
   end

   // An effective command owns the door for this cycle, so its tick is dropped.
   always_comb begin
      take_c = '0;
      for (int i = 0; i < 4; i++) begin
         st_d[i]  = st_q[i];
         amt_d[i] = amt_q[i];
         if (cmd_valid && cmd_id == 2'(i)) begin
            unique case (st_q[i])
               CLOSED, CLOSING: begin
                  if (cmd_open) begin
                     st_d[i]   = OPENING;
                     take_c[i] = 1'b1;
                  end
               end
               OPENING, OPEN: begin
                  if (!cmd_open) begin
                     st_d[i]   = CLOSING;
                     take_c[i] = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (frame_tick && !take_c[i]) begin
            unique case (st_q[i])
               OPENING: begin
                  if (amt_q[i] >= AMT_M1) begin
                     st_d[i]  = OPEN;
                     amt_d[i] = AMT_MX;
                  end else begin
                     amt_d[i] = amt_q[i] + 5'd1;
                  end
               end
               CLOSING: begin
                  if (amt_q[i] <= 5'd1) begin
                     st_d[i]  = CLOSED;
                     amt_d[i] = '0;
                  end else begin
                     amt_d[i] = amt_q[i] - 5'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      door_open   = '0;
      door_moving = '0;
      for (int i = 0; i < 4; i++) begin
         door_open[i]   = (st_q[i] == OPEN);
         door_moving[i] = (st_q[i] == OPENING) || (st_q[i] == CLOSING);
      end
   end

   function automatic logic [15:0] door_px(input int off, input logic [4:0] amt);
      return (off < int'(amt)) ? BG_COL : DOOR_COL;
   endfunction

   assign xi     = int'(x);
   assign yi     = int'(y);
   assign in_rng = (xi < W_PIX) && (yi < H_PIX);
   assign in_h   = (yi >= H_Y0) && (yi <= H_Y0 + WALL_T - 1);
   assign in_v   = (xi >= V_X0) && (xi <= V_X0 + WALL_T - 1);
   assign in_dl  = in_h && (xi >= GL_X0) && (xi < GL_X0 + GAP_W);
   assign in_dr  = in_h && (xi >= GR_X0) && (xi < GR_X0 + GAP_W);
   assign in_dt  = in_v && (yi >= GT_Y0) && (yi < GT_Y0 + GAP_W);
   assign in_db  = in_v && (yi >= GB_Y0) && (yi < GB_Y0 + GAP_W);

   always_comb begin
      pix_d = BG_COL;
      priority case (1'b1)
         !in_rng:     pix_d = BG_COL;
         in_dl:       pix_d = door_px(xi - GL_X0, amt_q[0]);
         in_dr:       pix_d = door_px(xi - GR_X0, amt_q[1]);
         in_dt:       pix_d = door_px(yi - GT_Y0, amt_q[2]);
         in_db:       pix_d = door_px(yi - GB_Y0, amt_q[3]);
         in_h | in_v: pix_d = WALL_COL;
         default:     pix_d = BG_COL;
      endcase
   end

   assign oled_data = pix_q;

endmodule
